// File: rtl/crossbar_output_arbiter.sv
// rtl/crossbar_output_arbiter.sv - packet-granular round-robin arbiter and mux for one crossbar output
module crossbar_output_arbiter #(
  parameter int NUM_QUEUES = 10,
  parameter int CTL_WIDTH  = 32,
  parameter int DATA_WIDTH = 480,
  parameter int MAX_IDLE   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_QUEUES-1:0]            in_req,
  input  logic [NUM_QUEUES-1:0]            in_wr,
  input  logic [NUM_QUEUES-1:0]            in_eop,
  input  logic [NUM_QUEUES*CTL_WIDTH-1:0]  in_ctl,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  output logic [NUM_QUEUES-1:0]            grant,
  output logic                             out_wr,
  output logic                             out_eop,
  output logic [CTL_WIDTH-1:0]             out_ctl,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             busy,
  output logic                             timeout_err
);

  localparam int PTR_W  = $clog2(NUM_QUEUES);
  localparam int IDLE_W = $clog2(MAX_IDLE) + 1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]        owner_q, owner_d;
  logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [NUM_QUEUES-1:0]   grant_q, grant_d;
  logic                    out_wr_q, out_wr_d;
  logic                    out_eop_q, out_eop_d;
  logic [CTL_WIDTH-1:0]    out_ctl_q, out_ctl_d;
  logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                    busy_q, busy_d;
  logic                    timeout_err_q, timeout_err_d;

  logic                    found_hi, found_lo;
  logic [PTR_W-1:0]        idx_hi, idx_lo, sel_idx;
  logic                    beat, eop_beat;
  logic [PTR_W-1:0]        next_ptr;
  logic [CTL_WIDTH-1:0]    g_ctl;
  logic [DATA_WIDTH-1:0]   g_data;

  // Round-robin search: lowest requester at or above rr_ptr wins, else lowest overall.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = NUM_QUEUES - 1; i >= 0; i--) begin
      if (in_req[i]) begin
        found_lo = 1'b1;
        idx_lo   = PTR_W'(i);
        if (i >= int'(rr_ptr_q)) begin
          found_hi = 1'b1;
          idx_hi   = PTR_W'(i);
        end
      end
    end
    sel_idx = found_hi ? idx_hi : idx_lo;
  end

  assign beat     = in_wr[owner_q];
  assign eop_beat = beat & in_eop[owner_q];
  assign g_ctl    = in_ctl[owner_q*CTL_WIDTH +: CTL_WIDTH];
  assign g_data   = in_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
  assign next_ptr = (owner_q == PTR_W'(NUM_QUEUES - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    idle_cnt_d    = idle_cnt_q;
    grant_d       = grant_q;
    out_wr_d      = 1'b0;
    out_eop_d     = 1'b0;
    out_ctl_d     = out_ctl_q;
    out_data_d    = out_data_q;
    busy_d        = busy_q;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        idle_cnt_d = '0;
        grant_d    = '0;
        busy_d     = 1'b0;
        if (found_lo) begin
          state_d = S_BUSY;
          owner_d = sel_idx;
          grant_d = NUM_QUEUES'(1) << sel_idx;
          busy_d  = 1'b1;
        end
      end
      S_BUSY: begin
        if (beat) begin
          out_wr_d   = 1'b1;
          out_eop_d  = in_eop[owner_q];
          out_ctl_d  = g_ctl;
          out_data_d = g_data;
          idle_cnt_d = '0;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
        // An eop beat on the threshold cycle takes the normal path, never a timeout.
        if (eop_beat || (!beat && idle_cnt_q == IDLE_W'(MAX_IDLE - 1))) begin
          timeout_err_d = !beat;
          state_d       = S_IDLE;
          grant_d       = '0;
          busy_d        = 1'b0;
          idle_cnt_d    = '0;
          rr_ptr_d      = next_ptr;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      idle_cnt_q    <= '0;
      grant_q       <= '0;
      out_wr_q      <= 1'b0;
      out_eop_q     <= 1'b0;
      out_ctl_q     <= '0;
      out_data_q    <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      idle_cnt_q    <= idle_cnt_d;
      grant_q       <= grant_d;
      out_wr_q      <= out_wr_d;
      out_eop_q     <= out_eop_d;
      out_ctl_q     <= out_ctl_d;
      out_data_q    <= out_data_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign grant       = grant_q;
  assign out_wr      = out_wr_q;
  assign out_eop     = out_eop_q;
  assign out_ctl     = out_ctl_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule
